// File: rtl/ballot_console.sv
// Voter-side front end: 4-digit keypad entry, password check, one-shot ballot arming.
// Optional BALLOT_LOCKOUT_EN: three consecutive rejects lock the console until rst.
module ballot_console #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic [15:0] valid_pw,
    input  logic [3:0]  btn,
    output logic [3:0]  vote_pulse,
    output logic        match,
    output logic        reject,
    output logic        timeout,
    output logic        busy,
    output logic [7:0]  voters
);

`ifdef BALLOT_LOCKOUT_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        CHECK   = 3'd2,
        ARMED   = 3'd3,
        LOCK    = 3'd4,
        REJECT  = 3'd5,
        LOCKOUT = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        CHECK   = 3'd2,
        ARMED   = 3'd3,
        LOCK    = 3'd4,
        REJECT  = 3'd5
    } state_t;
`endif

    // Counter value seen in the last cycle before the abandon edge.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    // A vote needs exactly one rising button with every other button low.
    function automatic logic single_rise(input logic [3:0] r, input logic [3:0] b);
        return (b == r) && (r != 4'b0000) && ((r & (r - 4'b0001)) == 4'b0000);
    endfunction

    state_t      state_r, state_s;
    logic [15:0] entry_r, entry_s;
    logic        bad_r, bad_s;
    logic [1:0]  idx_r, idx_s;
    logic [15:0] cnt_r, cnt_s;
    logic [3:0]  btn_q_r;
    logic [3:0]  rise_s;
    logic [3:0]  vote_s;
    logic [7:0]  voters_s;
    logic        timeout_s;
    logic        accept_s;
    logic        bad_digit_s;
    logic [3:0]  vote_pulse_r;
    logic        match_r, reject_r, timeout_r, busy_r;
    logic [7:0]  voters_r;
`ifdef BALLOT_LOCKOUT_EN
    logic [1:0]  rej_cnt_r, rej_cnt_s;
`endif

    assign rise_s      = btn & ~btn_q_r;
    assign bad_digit_s = (key_digit > 4'd9);

    // Next-state, datapath and pulse decode for the session FSM.
    always_comb begin
        state_s   = state_r;
        entry_s   = entry_r;
        bad_s     = bad_r;
        idx_s     = idx_r;
        vote_s    = 4'b0000;
        voters_s  = voters_r;
        timeout_s = 1'b0;
        accept_s  = 1'b0;
`ifdef BALLOT_LOCKOUT_EN
        rej_cnt_s = rej_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (key_valid) begin
                    entry_s  = {key_digit, 12'h000};
                    bad_s    = bad_digit_s;
                    idx_s    = 2'd1;
                    accept_s = 1'b1;
                    state_s  = COLLECT;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (key_valid) begin
                    accept_s = 1'b1;
                    bad_s    = bad_r | bad_digit_s;
                    case (idx_r)
                        2'd1:    entry_s[11:8] = key_digit;
                        2'd2:    entry_s[7:4]  = key_digit;
                        2'd3:    entry_s[3:0]  = key_digit;
                        default: entry_s       = entry_r;
                    endcase
                    if (idx_r == 2'd3) begin
                        idx_s   = 2'd0;
                        state_s = CHECK;
                    end else begin
                        idx_s = idx_r + 2'd1;
                    end
                end else if (cnt_r == TO_LAST) begin
                    timeout_s = 1'b1;
                    entry_s   = 16'h0000;
                    bad_s     = 1'b0;
                    idx_s     = 2'd0;
                    state_s   = IDLE;
                end else begin
                    state_s = COLLECT;
                end
            end
            CHECK: begin
                if ((entry_r == valid_pw) && !bad_r) begin
                    state_s = ARMED;
`ifdef BALLOT_LOCKOUT_EN
                    rej_cnt_s = 2'd0;
`endif
                end else begin
                    state_s = REJECT;
                end
            end
            REJECT: begin
                entry_s = 16'h0000;
                bad_s   = 1'b0;
                idx_s   = 2'd0;
`ifdef BALLOT_LOCKOUT_EN
                if (rej_cnt_r == 2'd2) begin
                    state_s = LOCKOUT;
                end else begin
                    rej_cnt_s = rej_cnt_r + 2'd1;
                    state_s   = IDLE;
                end
`else
                state_s = IDLE;
`endif
            end
            ARMED: begin
                // A vote on the abandon edge still counts: the voter acted in time.
                if (single_rise(rise_s, btn)) begin
                    vote_s   = rise_s;
                    voters_s = (voters_r == 8'hFF) ? 8'hFF : (voters_r + 8'd1);
                    entry_s  = 16'h0000;
                    state_s  = LOCK;
                end else if (cnt_r == TO_LAST) begin
                    timeout_s = 1'b1;
                    entry_s   = 16'h0000;
                    bad_s     = 1'b0;
                    state_s   = IDLE;
                end else begin
                    state_s = ARMED;
                end
            end
            LOCK: begin
                if (btn == 4'b0000) begin
                    state_s = IDLE;
                end else begin
                    state_s = LOCK;
                end
            end
`ifdef BALLOT_LOCKOUT_EN
            LOCKOUT: begin
                state_s = LOCKOUT;
            end
`endif
            default: begin
                entry_s = 16'h0000;
                bad_s   = 1'b0;
                idx_s   = 2'd0;
                state_s = IDLE;
            end
        endcase

        if ((state_s != state_r) || accept_s) begin
            cnt_s = 16'd0;
        end else begin
            cnt_s = cnt_r + 16'd1;
        end
    end

    // State, datapath and registered outputs; outputs decode from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            entry_r      <= 16'h0000;
            bad_r        <= 1'b0;
            idx_r        <= 2'd0;
            cnt_r        <= 16'd0;
            btn_q_r      <= 4'b0000;
            vote_pulse_r <= 4'b0000;
            match_r      <= 1'b0;
            reject_r     <= 1'b0;
            timeout_r    <= 1'b0;
            busy_r       <= 1'b0;
            voters_r     <= 8'd0;
`ifdef BALLOT_LOCKOUT_EN
            rej_cnt_r    <= 2'd0;
`endif
        end else begin
            state_r      <= state_s;
            entry_r      <= entry_s;
            bad_r        <= bad_s;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            btn_q_r      <= btn;
            vote_pulse_r <= vote_s;
            match_r      <= (state_s == ARMED);
            reject_r     <= (state_s == REJECT);
            timeout_r    <= timeout_s;
            busy_r       <= (state_s != IDLE);
            voters_r     <= voters_s;
`ifdef BALLOT_LOCKOUT_EN
            rej_cnt_r    <= rej_cnt_s;
`endif
        end
    end

    assign vote_pulse = vote_pulse_r;
    assign match      = match_r;
    assign reject     = reject_r;
    assign timeout    = timeout_r;
    assign busy       = busy_r;
    assign voters     = voters_r;

endmodule

// File: tb/tb_ballot_console.sv
// Directed self-checking bench for ballot_console (TIMEOUT=8); honours BALLOT_LOCKOUT_EN.
module tb_ballot_console;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'h0;
    logic [15:0] valid_pw = 16'h2987;
    logic [3:0]  btn = 4'b0000;
    logic [3:0]  vote_pulse;
    logic        match, reject, timeout, busy;
    logic [7:0]  voters;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int snap;

    ballot_console #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
        .valid_pw(valid_pw), .btn(btn), .vote_pulse(vote_pulse), .match(match),
        .reject(reject), .timeout(timeout), .busy(busy), .voters(voters)
    );

    always #5 clk = ~clk;

    // Count every cycle in which any vote pulse is seen.
    always @(negedge clk) begin
        if (vote_pulse !== 4'b0000) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter_pw(input logic [15:0] pw);
        press_key(pw[15:12]);
        press_key(pw[11:8]);
        press_key(pw[7:4]);
        press_key(pw[3:0]);
    endtask

    task automatic session_vote(input logic [3:0] b);
        enter_pw(16'h2987);
        tick();
        btn = b;
        tick();
        btn = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({vote_pulse, match, reject, timeout, busy, voters} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0000", {vote_pulse, match, reject, timeout, busy, voters});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_valid_vote();
        enter_pw(16'h2987);
        checks++;
        if ({match, busy} !== 2'b01) begin
            errors++;
            $display("FAIL check_state got match,busy=%b want=01", {match, busy});
        end
        tick();
        checks++;
        if ({match, reject} !== 2'b10) begin
            errors++;
            $display("FAIL arm got match,reject=%b want=10", {match, reject});
        end
        btn = 4'b0001;
        tick();
        checks++;
        if ({vote_pulse, match, voters} !== {4'b0001, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL vote_a got pulse=%b match=%b voters=%0d want 0001 0 1", vote_pulse, match, voters);
        end
        tick();
        checks++;
        if ({vote_pulse, busy} !== {4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL lock_hold got pulse=%b busy=%b want 0000 1", vote_pulse, busy);
        end
        btn = 4'b0000;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL release_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_mismatch();
        snap = pulse_cnt;
        enter_pw(16'h3217);
        tick();
        checks++;
        if ({reject, match} !== 2'b10) begin
            errors++;
            $display("FAIL mismatch_reject got reject,match=%b want=10", {reject, match});
        end
        tick();
        checks++;
        if ({reject, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reject_one_cycle got reject,busy=%b want=00", {reject, busy});
        end
        valid_pw = 16'h2A87;
        enter_pw(16'h2A87);
        tick();
        checks++;
        if ({reject, match} !== 2'b10) begin
            errors++;
            $display("FAIL bad_digit_reject got reject,match=%b want=10", {reject, match});
        end
        valid_pw = 16'h2987;
        tick();
        checks++;
        if (pulse_cnt !== snap) begin
            errors++;
            $display("FAIL reject_no_vote got pulses=%0d want=%0d", pulse_cnt, snap);
        end
    endtask

    task automatic test_double_press();
        enter_pw(16'h2987);
        tick();
        btn = 4'b0101;
        tick();
        checks++;
        if ({vote_pulse, match} !== {4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL double_ignored got pulse=%b match=%b want 0000 1", vote_pulse, match);
        end
        btn = 4'b0000;
        tick();
        btn = 4'b0100;
        tick();
        checks++;
        if ({vote_pulse, voters} !== {4'b0100, 8'd2}) begin
            errors++;
            $display("FAIL single_after_double got pulse=%b voters=%0d want 0100 2", vote_pulse, voters);
        end
        btn = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_timeout_armed();
        enter_pw(16'h2987);
        tick();
        repeat (7) tick();
        checks++;
        if ({timeout, match} !== 2'b01) begin
            errors++;
            $display("FAIL armed_before_to got timeout,match=%b want=01", {timeout, match});
        end
        tick();
        checks++;
        if ({timeout, match, voters} !== {1'b1, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL armed_to got to=%b match=%b voters=%0d want 1 0 2", timeout, match, voters);
        end
        tick();
        checks++;
        if ({timeout, busy} !== 2'b00) begin
            errors++;
            $display("FAIL armed_to_pulse got timeout,busy=%b want=00", {timeout, busy});
        end
    endtask

    task automatic test_timeout_collect();
        press_key(4'h2);
        press_key(4'h9);
        repeat (7) tick();
        checks++;
        if ({timeout, busy} !== 2'b01) begin
            errors++;
            $display("FAIL collect_before_to got timeout,busy=%b want=01", {timeout, busy});
        end
        tick();
        checks++;
        if ({timeout, busy} !== 2'b10) begin
            errors++;
            $display("FAIL collect_to got timeout,busy=%b want=10", {timeout, busy});
        end
        enter_pw(16'h2987);
        tick();
        checks++;
        if (match !== 1'b1) begin
            errors++;
            $display("FAIL fresh_after_to got match=%b want=1", match);
        end
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_held_button();
        btn = 4'b1000;
        enter_pw(16'h2987);
        tick();
        snap = pulse_cnt;
        press_key(4'h5);
        tick();
        checks++;
        if ({match, vote_pulse, pulse_cnt == snap} !== {1'b1, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL held_no_vote got match=%b pulse=%b pulses=%0d want 1 0000 %0d", match, vote_pulse, pulse_cnt, snap);
        end
        btn = 4'b0000;
        tick();
        btn = 4'b1000;
        tick();
        checks++;
        if ({vote_pulse, voters} !== {4'b1000, 8'd4}) begin
            errors++;
            $display("FAIL repress_vote got pulse=%b voters=%0d want 1000 4", vote_pulse, voters);
        end
        press_key(4'h2);
        tick();
        checks++;
        if ({busy, match} !== 2'b10) begin
            errors++;
            $display("FAIL lock_ignores_key got busy,match=%b want=10", {busy, match});
        end
        btn = 4'b0000;
        tick();
        enter_pw(16'h2987);
        tick();
        checks++;
        if (match !== 1'b1) begin
            errors++;
            $display("FAIL after_lock_entry got match=%b want=1", match);
        end
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_lockout();
        repeat (3) begin
            enter_pw(16'h1111);
            tick();
            tick();
        end
        enter_pw(16'h2987);
        tick();
`ifdef BALLOT_LOCKOUT_EN
        checks++;
        if ({match, busy} !== 2'b01) begin
            errors++;
            $display("FAIL lockout_stuck got match,busy=%b want=01", {match, busy});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, voters} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL lockout_rst got busy=%b voters=%0d want 0 0", busy, voters);
        end
        enter_pw(16'h2987);
        tick();
`endif
        checks++;
        if (match !== 1'b1) begin
            errors++;
            $display("FAIL fourth_entry_arms got match=%b want=1", match);
        end
    endtask

    task automatic test_reset_mid();
        btn = 4'b0010;
        tick();
        checks++;
        if (vote_pulse !== 4'b0010) begin
            errors++;
            $display("FAIL pre_reset_vote got pulse=%b want=0010", vote_pulse);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({vote_pulse, match, voters} !== {4'b0000, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL async_reset got pulse=%b match=%b voters=%0d want 0000 0 0", vote_pulse, match, voters);
        end
        btn = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        repeat (255) session_vote(4'b0001);
        checks++;
        if (voters !== 8'd255) begin
            errors++;
            $display("FAIL reach_255 got voters=%0d want=255", voters);
        end
        enter_pw(16'h2987);
        tick();
        btn = 4'b0010;
        tick();
        checks++;
        if ({vote_pulse, voters} !== {4'b0010, 8'hFF}) begin
            errors++;
            $display("FAIL saturated_vote got pulse=%b voters=%0d want 0010 255", vote_pulse, voters);
        end
        btn = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_valid_vote();
        test_mismatch();
        test_double_press();
        test_timeout_armed();
        test_timeout_collect();
        test_held_button();
        test_lockout();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
